mat_result_serializer: RTL and testbench

Output-side companion to the matrix-vector engine. Accepts one completed result vector of `elementsNum` parallel elements through a valid/ready handshake that connects directly to the engine's `out`/`valid_out`/`ready_out`. Double-buffers the vectors and re-emits them one element per cycle on a narrow stream with a last-element marker. Sits between the engine and the downstream serial sink, so the engine can hand off vector N+1 while vector N is still draining.

---
 rtl/mat_pkg.sv | 25 ++
 rtl/mat_result_serializer.sv | 109 ++++++++++
 tb/tb_mat_result_serializer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared result-width, slot-index and saturation helpers for the matrix-vector path
package mat_pkg;

  localparam int MAT_MAX_W = 64;

  typedef logic [MAT_MAX_W-1:0] mat_word_t;

  // One bit selects between the two vector slots of the serializer.
  typedef logic slot_idx_t;

  function automatic int mat_res_width(input int data_width, input int elements_num);
    return data_width * 2 + $clog2(elements_num) + 1;
  endfunction

  function automatic mat_word_t mat_sat(input mat_word_t value, input int out_w);
    mat_word_t limit;
    if (out_w >= MAT_MAX_W) begin
      limit = '1;
    end else begin
      limit = (mat_word_t'(1) << out_w) - mat_word_t'(1);
    end
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/mat_result_serializer.sv
// rtl/mat_result_serializer.sv - double-buffered vector-to-element serializer; MAT_RESULT_SAT_EN selects saturation over truncation
module mat_result_serializer
  import mat_pkg::*;
#(
  parameter int elementsNum = 4,
  parameter int dataWidth   = 4,
  parameter int outWidth    = 8,
  localparam int inWidth    = mat_res_width(dataWidth, elementsNum)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [inWidth-1:0] vec_in [elementsNum],
  input  logic               vec_valid,
  output logic               vec_ready,
  output logic [outWidth-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               sat_flag
);

  localparam int idxW = $clog2(elementsNum);
  localparam logic [idxW-1:0] last_idx = idxW'(elementsNum - 1);

  logic [inWidth-1:0] slot_q [2][elementsNum];
  logic [1:0]         full_q;
  logic [1:0]         full_next;
  slot_idx_t          wr_ptr_q;
  slot_idx_t          rd_ptr_q;
  logic [idxW-1:0]    idx_q;
  logic               accept;
  logic               emit;
  logic               release_vec;
  logic [inWidth-1:0] cur_elem;

  // vec_ready depends only on registered state, keeping the engine handshake loop-free.
  always_comb begin
    vec_ready   = ~full_q[wr_ptr_q];
    out_valid   = full_q[rd_ptr_q];
    out_last    = out_valid & (idx_q == last_idx);
    accept      = vec_valid & vec_ready;
    emit        = out_valid & out_ready;
    release_vec = emit & (idx_q == last_idx);
    cur_elem    = slot_q[rd_ptr_q][idx_q];
  end

  always_comb begin
    full_next = full_q;
    if (release_vec) full_next[rd_ptr_q] = 1'b0;
    if (accept)      full_next[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst && accept) begin
      for (int i = 0; i < elementsNum; i++) begin
        slot_q[wr_ptr_q][i] <= vec_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      full_q <= full_next;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (emit) begin
        if (release_vec) begin
          idx_q    <= '0;
          rd_ptr_q <= ~rd_ptr_q;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

`ifdef MAT_RESULT_SAT_EN
  mat_word_t elem_word;
  mat_word_t sat_word;
  logic      sat_q;

  always_comb begin
    elem_word = mat_word_t'(cur_elem);
    sat_word  = mat_sat(elem_word, outWidth);
    out_data  = outWidth'(sat_word);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (emit && (sat_word != elem_word)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  always_comb begin
    out_data = outWidth'(cur_elem);
  end

  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mat_result_serializer.sv
// tb/tb_mat_result_serializer.sv - randomized and directed bench for mat_result_serializer against an element-queue model
module tb_mat_result_serializer;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int OW = 8;
  localparam int IW = DW * 2 + $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] vec_in [N];
  logic          vec_valid;
  logic          vec_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          sat_flag;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  bit exp_sat = 1'b0;

  always #5 clk = ~clk;

  mat_result_serializer #(
    .elementsNum(N),
    .dataWidth  (DW),
    .outWidth   (OW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vec_in   (vec_in),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .sat_flag (sat_flag)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_out(input int e);
`ifdef MAT_RESULT_SAT_EN
    return (e > 255) ? 255 : e;
`else
    return e % 256;
`endif
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model across the edge.
  task automatic step(input bit r, input bit v, input int e0, input int e1,
                      input int e2, input int e3, input bit ordy);
    int occ;
    bit rdy_e;
    bit ov_e;
    rst       = r;
    vec_valid = v;
    vec_in[0] = IW'(e0);
    vec_in[1] = IW'(e1);
    vec_in[2] = IW'(e2);
    vec_in[3] = IW'(e3);
    out_ready = ordy;
    #2;
    occ   = (exp_q.size() + N - 1) / N;
    rdy_e = (occ < 2);
    ov_e  = (exp_q.size() > 0);
    chk("vec_ready", 64'(vec_ready), 64'(rdy_e));
    chk("out_valid", 64'(out_valid), 64'(ov_e));
    if (ov_e) begin
      chk("out_data", 64'(out_data), 64'(exp_out(exp_q[0])));
      chk("out_last", 64'(out_last), 64'(exp_q.size() % N == 1));
    end else begin
      chk("out_last_idle", 64'(out_last), 64'(0));
    end
    chk("sat_flag", 64'(sat_flag), 64'(exp_sat));
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
      exp_sat = 1'b0;
    end else begin
      if (ov_e && ordy) begin
`ifdef MAT_RESULT_SAT_EN
        if (exp_q[0] > 255) exp_sat = 1'b1;
`endif
        void'(exp_q.pop_front());
      end
      if (v && rdy_e) begin
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    rst       = 1'b0;
    vec_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) vec_in[i] = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step(0, 1, 1, 2, 3, 4, 1);

    step(1, 1, 1, 2, 3, 4, 1);
    idle(6, 1);

    step(1, 1, 1, 2, 3, 4, 1);
    step(1, 1, 5, 6, 7, 8, 1);
    step(1, 1, 9, 10, 11, 12, 1);
    idle(14, 1);

    step(1, 1, 1, 2, 3, 4, 0);
    step(1, 1, 5, 6, 7, 8, 0);
    step(1, 1, 9, 10, 11, 12, 0);
    step(1, 1, 9, 10, 11, 12, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 9, 10, 11, 12, bit'(i % 2 == 0));
    idle(30, 1);

    step(1, 1, 300, 5, 2047, 255, 1);
    idle(6, 1);

    step(1, 1, 7, 8, 9, 10, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 2, 3, 4, 1);
    idle(6, 1);

    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 60) != 0),
           ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
           int'($urandom_range(0, 400)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 6));
    end
    idle(12, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
